spi_slave_rx: RTL and testbench



---
 rtl/spi_slave_rx.sv | 155 +++++++++++++++
 tb/tb_spi_slave_rx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI mode-3 (CPOL=1, CPHA=1) slave receiver: oversamples sclk/mosi/ss in the clk100M domain,
// deserialises words and hands them to the fabric through a valid/ready holding register.
module spi_slave_rx #(
    parameter int DATA_W    = 16,
    parameter int MSB_FIRST = 1
) (
    input  logic              clk100M,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              mosi,
    input  logic              ss,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic               sclk_s1, sclk_s2, sclk_d;
    logic               mosi_s1, mosi_s2;
    logic               ss_s1, ss_s2, ss_d;
    logic               sclk_rise, ss_fall, ss_rise;
    logic [DATA_W-1:0]  shift_q, shift_d, shifted;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  word_q, word_d;
    logic               done_q, done_d;
    logic               frame_err_d;
    logic               consume, ovr_evt;

    // sclk and ss idle high, so their synchroniser stages reset high to avoid false edges.
    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            sclk_s1 <= 1'b1;
            sclk_s2 <= 1'b1;
            sclk_d  <= 1'b1;
            mosi_s1 <= 1'b0;
            mosi_s2 <= 1'b0;
            ss_s1   <= 1'b1;
            ss_s2   <= 1'b1;
            ss_d    <= 1'b1;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            mosi_s1 <= mosi;
            mosi_s2 <= mosi_s1;
            ss_s1   <= ss;
            ss_s2   <= ss_s1;
            ss_d    <= ss_s2;
        end
    end

    assign sclk_rise = sclk_s2 & ~sclk_d;
    assign ss_fall   = ~ss_s2 & ss_d;
    assign ss_rise   = ss_s2 & ~ss_d;
    assign busy      = ~ss_s2;

    always_comb begin
        if (MSB_FIRST != 0) begin
            shifted = {shift_q[DATA_W-2:0], mosi_s2};
        end else begin
            shifted = {mosi_s2, shift_q[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            word_q    <= '0;
            done_q    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            word_q    <= word_d;
            done_q    <= done_d;
            frame_err <= frame_err_d;
        end
    end

    // ss_rise is checked before sampling so a coincident sclk edge never contributes a bit.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        done_d      = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    shift_d = '0;
                end
            end
            SHIFT: begin
                if (ss_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_q != '0);
                    cnt_d       = '0;
                    shift_d     = '0;
                end else if (sclk_rise && !ss_s2) begin
                    shift_d = shifted;
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        cnt_d  = '0;
                        word_d = shifted;
                        done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign consume = rx_valid & rx_ready;
    assign ovr_evt = done_q & rx_valid & ~consume;

    // A word arriving while the previous one is still unconsumed is dropped and flagged.
    always_ff @(posedge clk100M or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (done_q && (!rx_valid || consume)) begin
                rx_data  <= word_q;
                rx_valid <= 1'b1;
            end else if (consume) begin
                rx_valid <= 1'b0;
            end
            if (ovr_evt) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: mode-3 frames driven bit by bit, outputs checked against
// hand-computed values on an MSB-first and an LSB-first instance.
module tb_spi_slave_rx;

    localparam int HALF = 10;

    logic        clk100M;
    logic        rst_n;
    logic        sclk;
    logic        mosi;
    logic        ss;
    logic        rx_ready;
    logic        ovr_clr;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;
    logic [15:0] lsb_data;
    logic        lsb_valid;
    logic        lsb_err;
    logic        lsb_ovr;
    logic        lsb_busy;

    int checks = 0;
    int passes = 0;
    int validCycles = 0;
    int errCycles = 0;

    spi_slave_rx #(.DATA_W(16), .MSB_FIRST(1)) dut (
        .clk100M(clk100M), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .ovr_clr(ovr_clr), .busy(busy)
    );

    spi_slave_rx #(.DATA_W(16), .MSB_FIRST(0)) dut_lsb (
        .clk100M(clk100M), .rst_n(rst_n), .sclk(sclk), .mosi(mosi), .ss(ss),
        .rx_data(lsb_data), .rx_valid(lsb_valid), .rx_ready(1'b1),
        .frame_err(lsb_err), .overrun(lsb_ovr), .ovr_clr(1'b0), .busy(lsb_busy)
    );

    initial clk100M = 1'b0;
    always #5 clk100M = ~clk100M;

    always @(negedge clk100M) begin
        if (rx_valid) validCycles++;
        if (frame_err) errCycles++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk100M);
    endtask

    task automatic sendBit(input logic b, input int tail);
        @(negedge clk100M);
        sclk = 1'b0;
        mosi = b;
        waitNeg(HALF);
        sclk = 1'b1;
        waitNeg(tail);
    endtask

    task automatic applyStimulus(input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) sendBit(word[15-i], HALF);
    endtask

    task automatic ssLow();
        @(negedge clk100M);
        ss = 1'b0;
        waitNeg(HALF);
    endtask

    task automatic ssHigh();
        @(negedge clk100M);
        ss = 1'b1;
        waitNeg(HALF);
    endtask

    initial begin
        rst_n = 1'b0; sclk = 1'b1; mosi = 1'b0; ss = 1'b1; rx_ready = 1'b0; ovr_clr = 1'b0;
        waitNeg(3);
        checkOutput("reset_valid", rx_valid, 0);
        checkOutput("reset_data", rx_data, 0);
        checkOutput("reset_busy", busy, 0);
        rst_n = 1'b1;
        waitNeg(5);

        // basic word with consumer always ready
        rx_ready = 1'b1;
        validCycles = 0; errCycles = 0;
        ssLow();
        checkOutput("busy_high", busy, 1);
        applyStimulus(16'b1000000110000001, 16);
        checkOutput("basic_data", rx_data, 16'h8181);
        checkOutput("basic_pulse", validCycles, 1);
        checkOutput("basic_ovr", overrun, 0);
        @(negedge clk100M);
        ss = 1'b1;
        @(negedge clk100M);
        checkOutput("busy_still", busy, 1);
        @(negedge clk100M);
        checkOutput("busy_fall", busy, 0);
        checkOutput("basic_err", errCycles, 0);
        waitNeg(HALF);

        // latency and backpressure
        rx_ready = 1'b0;
        ssLow();
        applyStimulus(16'hA5C3, 15);
        sendBit(1'b1, 0);
        repeat (3) @(posedge clk100M);
        #1 checkOutput("lat_e2", rx_valid, 0);
        @(posedge clk100M);
        #1 checkOutput("lat_e3", rx_valid, 1);
        waitNeg(HALF);
        checkOutput("hold_valid", rx_valid, 1);
        checkOutput("hold_data", rx_data, 16'hA5C3);
        rx_ready = 1'b1;
        @(negedge clk100M);
        rx_ready = 1'b0;
        checkOutput("consume", rx_valid, 0);
        ssHigh();

        // overrun: second word dropped while first unconsumed
        ssLow();
        applyStimulus(16'h1111, 16);
        applyStimulus(16'h2222, 16);
        ssHigh();
        checkOutput("ovr_data", rx_data, 16'h1111);
        checkOutput("ovr_flag", overrun, 1);
        ovr_clr = 1'b1;
        @(negedge clk100M);
        ovr_clr = 1'b0;
        checkOutput("ovr_clr", overrun, 0);
        rx_ready = 1'b1;
        @(negedge clk100M);
        rx_ready = 1'b0;
        checkOutput("ovr_drain", rx_valid, 0);

        // consume on the completion cycle replaces the word without overrun
        ssLow();
        applyStimulus(16'h1111, 16);
        applyStimulus(16'h2222, 15);
        sendBit(1'b0, 0);
        waitNeg(3);
        rx_ready = 1'b1;
        @(negedge clk100M);
        rx_ready = 1'b0;
        checkOutput("swap_data", rx_data, 16'h2222);
        checkOutput("swap_valid", rx_valid, 1);
        checkOutput("swap_ovr", overrun, 0);
        waitNeg(HALF);
        ssHigh();
        rx_ready = 1'b1;
        waitNeg(2);

        // aborted frame after 9 bits
        validCycles = 0; errCycles = 0;
        ssLow();
        applyStimulus(16'hFFFF, 9);
        ssHigh();
        checkOutput("abort_err", errCycles, 1);
        checkOutput("abort_valid", validCycles, 0);
        checkOutput("abort_keep", rx_data, 16'h2222);
        ssLow();
        applyStimulus(16'h00FF, 16);
        ssHigh();
        checkOutput("after_abort", rx_data, 16'h00FF);
        checkOutput("after_abort_err", errCycles, 1);

        // sclk toggling with ss high is ignored
        validCycles = 0; errCycles = 0;
        applyStimulus(16'hFFFF, 16);
        waitNeg(HALF);
        checkOutput("ign_valid", validCycles, 0);
        checkOutput("ign_data", rx_data, 16'h00FF);

        // LSB-first instance sees the same stream
        ssLow();
        applyStimulus(16'h8000, 16);
        ssHigh();
        checkOutput("lsb_data", lsb_data, 16'h0001);
        checkOutput("msb_data", rx_data, 16'h8000);
        checkOutput("ign_err", errCycles, 0);

        // reset mid-frame
        ssLow();
        applyStimulus(16'hF000, 5);
        @(negedge clk100M);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_data", rx_data, 0);
        checkOutput("rst_valid", rx_valid, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_err", frame_err, 0);
        checkOutput("rst_lsb", lsb_data, 0);
        ss = 1'b1;
        waitNeg(3);
        rst_n = 1'b1;
        errCycles = 0;
        waitNeg(5);
        ssLow();
        applyStimulus(16'hBEEF, 16);
        ssHigh();
        checkOutput("beef_data", rx_data, 16'hBEEF);
        checkOutput("beef_err", errCycles, 0);
        checkOutput("beef_ovr", overrun, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
